// File: rtl/rf_wb_arbiter.sv
// Write-side driver for the 32x32 register file: MEM/WB stage register, write-back mux,
// and a small queue of long-latency results that drain on cycles the pipeline leaves idle.
module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          m_valid,
  input  logic          m_regwrite,
  input  logic [4:0]    m_dst,
  input  logic [1:0]    m_wdsel,
  input  logic [31:0]   m_alu,
  input  logic [31:0]   m_mem,
  input  logic [31:0]   m_pc4,
  input  logic          lu_valid,
  input  logic [4:0]    lu_dst,
  input  logic [31:0]   lu_data,
  output logic          lu_ready,
  output logic          rf_wr,
  output logic [4:0]    rf_a3,
  output logic [31:0]   rf_wd,
  output logic [31:0]   q_busy,
  output logic [CW-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MEM = 2'b01,
    WD_PC4 = 2'b10,
    WD_RSV = 2'b11
  } wdsel_e;

  // MEM/WB stage register
  logic        wb_valid_q, wb_regwrite_q, wb_done_q;
  logic [4:0]  wb_dst_q;
  wdsel_e      wb_wdsel_q;
  logic [31:0] wb_alu_q, wb_mem_q, wb_pc4_q;

  // Long-latency result queue
  logic [4:0]       q_dst_q  [DEPTH];
  logic [31:0]      q_data_q [DEPTH];
  logic [DEPTH-1:0] q_live_q;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic        pw, pop, store;
  logic [31:0] wb_wd;

  // A held instruction writes once; wb_done suppresses the repeats while stalled.
  assign pw       = wb_valid_q & wb_regwrite_q & (wb_dst_q != 5'd0) & ~wb_done_q;
  assign pop      = ~pw & (count_q != '0);
  assign lu_ready = {1'b0, count_q} < DEPTH_W;
  assign store    = lu_valid & lu_ready & (lu_dst != 5'd0);
  assign q_count  = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_done_q     <= 1'b0;
      wb_dst_q      <= 5'd0;
      wb_wdsel_q    <= WD_ALU;
      wb_alu_q      <= '0;
      wb_mem_q      <= '0;
      wb_pc4_q      <= '0;
    end else if (flush_i) begin
      wb_valid_q <= 1'b0;
      wb_done_q  <= 1'b0;
    end else if (stall_i) begin
      if (pw) wb_done_q <= 1'b1;
    end else begin
      wb_valid_q    <= m_valid;
      wb_regwrite_q <= m_regwrite;
      wb_done_q     <= 1'b0;
      wb_dst_q      <= m_dst;
      wb_wdsel_q    <= wdsel_e'(m_wdsel);
      wb_alu_q      <= m_alu;
      wb_mem_q      <= m_mem;
      wb_pc4_q      <= m_pc4;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    wb_wd = wb_alu_q;
    case (wb_wdsel_q)
      WD_MEM:  wb_wd = wb_mem_q;
      WD_PC4:  wb_wd = wb_pc4_q;
      default: wb_wd = wb_alu_q;
    endcase

    rf_wr = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    if (pw) begin
      rf_wr = 1'b1;
      rf_a3 = wb_dst_q;
      rf_wd = wb_wd;
    end else if (pop && q_live_q[rd_ptr_q]) begin
      rf_wr = 1'b1;
      rf_a3 = q_dst_q[rd_ptr_q];
      rf_wd = q_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    if (store && !pop)      count_d = count_q + CW'(1);
    else if (!store && pop) count_d = count_q - CW'(1);
  end

  // Only the live bits and pointers define occupancy, so only they need reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_live_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // A pipeline write to r makes any older queued result for r stale.
      if (pw) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_live_q[i] && (q_dst_q[i] == wb_dst_q)) q_live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      if (store) begin
        q_live_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // NOTE: queue payload storage is deliberately not reset; the live bits gate its use.
  always_ff @(posedge clk) begin
    if (store) begin
      q_dst_q[wr_ptr_q]  <= lu_dst;
      q_data_q[wr_ptr_q] <= lu_data;
    end
  end

  always_comb begin
    q_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live_q[i]) q_busy[q_dst_q[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_i, flush_i, m_valid, m_regwrite;
  logic [4:0]    m_dst;
  logic [1:0]    m_wdsel;
  logic [31:0]   m_alu, m_mem, m_pc4;
  logic          lu_valid;
  logic [4:0]    lu_dst;
  logic [31:0]   lu_data;
  logic          lu_ready, rf_wr;
  logic [4:0]    rf_a3;
  logic [31:0]   rf_wd, q_busy;
  logic [CW-1:0] q_count;

  rf_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_dst(m_dst), .m_wdsel(m_wdsel),
    .m_alu(m_alu), .m_mem(m_mem), .m_pc4(m_pc4),
    .lu_valid(lu_valid), .lu_dst(lu_dst), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .q_busy(q_busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, mv, mrw;
    logic [4:0]  mdst;
    logic [1:0]  wdsel;
    logic [31:0] alu, mem, pc4;
    logic        luv;
    logic [4:0]  ludst;
    logic [31:0] ludata;
  } stim_t;

  typedef struct {
    logic        valid, regwrite, done;
    logic [4:0]  dst;
    logic [1:0]  wdsel;
    logic [31:0] alu, mem, pc4;
  } wb_t;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
    logic        live;
  } ent_t;

  wb_t         mwb;
  ent_t        mq[$];
  logic [31:0] dut_rf [32];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  function automatic stim_t idle();
    stim_t s;
    s.stall = 1'b0; s.flush = 1'b0; s.mv = 1'b0; s.mrw = 1'b0;
    s.mdst = 5'd0; s.wdsel = 2'b00;
    s.alu = 32'd0; s.mem = 32'd0; s.pc4 = 32'd0;
    s.luv = 1'b0; s.ludst = 5'd0; s.ludata = 32'd0;
    return s;
  endfunction

  // Unselected sources carry distinct junk so a wrong mux leg is visible.
  function automatic stim_t op(input logic [4:0] dst, input logic [1:0] sel, input logic [31:0] v);
    stim_t s = idle();
    s.mv = 1'b1; s.mrw = 1'b1; s.mdst = dst; s.wdsel = sel;
    s.alu = 32'hA1A1_0000 ^ v;
    s.mem = 32'hB2B2_0000 ^ v;
    s.pc4 = 32'hC3C3_0000 ^ v;
    case (sel)
      2'b01:   s.mem = v;
      2'b10:   s.pc4 = v;
      default: s.alu = v;
    endcase
    return s;
  endfunction

  function automatic stim_t with_lu(input stim_t s_in, input logic [4:0] dst, input logic [31:0] d);
    stim_t s = s_in;
    s.luv = 1'b1; s.ludst = dst; s.ludata = d;
    return s;
  endfunction

  function automatic stim_t stalled();
    stim_t s = idle();
    s.stall = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.stall  = ($urandom_range(0, 3) == 0);
    s.flush  = ($urandom_range(0, 9) == 0);
    s.mv     = ($urandom_range(0, 3) != 0);
    s.mrw    = ($urandom_range(0, 3) != 0);
    s.mdst   = 5'($urandom_range(0, 7));
    s.wdsel  = 2'($urandom_range(0, 3));
    s.alu    = $urandom;
    s.mem    = $urandom;
    s.pc4    = $urandom;
    s.luv    = ($urandom_range(0, 1) == 1);
    s.ludst  = 5'($urandom_range(0, 7));
    s.ludata = $urandom;
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    mwb.valid = 1'b0; mwb.regwrite = 1'b0; mwb.done = 1'b0;
    mwb.dst = 5'd0; mwb.wdsel = 2'b00;
    mwb.alu = 32'd0; mwb.mem = 32'd0; mwb.pc4 = 32'd0;
    mq.delete();
  endtask

  // Entered at a falling edge: drive, check state-derived outputs, advance model at the rising edge.
  task automatic step(input stim_t s);
    logic        pw, ewr, eready;
    logic [4:0]  ea3;
    logic [31:0] wd, ewd, ebusy;
    ent_t        e;
    stall_i = s.stall; flush_i = s.flush; m_valid = s.mv; m_regwrite = s.mrw;
    m_dst = s.mdst; m_wdsel = s.wdsel; m_alu = s.alu; m_mem = s.mem; m_pc4 = s.pc4;
    lu_valid = s.luv; lu_dst = s.ludst; lu_data = s.ludata;

    pw = mwb.valid && mwb.regwrite && (mwb.dst != 5'd0) && !mwb.done;
    case (mwb.wdsel)
      2'b01:   wd = mwb.mem;
      2'b10:   wd = mwb.pc4;
      default: wd = mwb.alu;
    endcase
    ewr = 1'b0; ea3 = 5'd0; ewd = 32'd0;
    if (pw) begin
      ewr = 1'b1; ea3 = mwb.dst; ewd = wd;
    end else if (mq.size() > 0 && mq[0].live) begin
      ewr = 1'b1; ea3 = mq[0].dst; ewd = mq[0].data;
    end
    ebusy = 32'd0;
    foreach (mq[i]) if (mq[i].live) ebusy[mq[i].dst] = 1'b1;
    eready = (mq.size() < DEPTH);

    #1;
    check_eq("rf_wr", 32'(rf_wr), 32'(ewr));
    check_eq("rf_a3", 32'(rf_a3), 32'(ea3));
    check_eq("rf_wd", rf_wd, ewd);
    check_eq("lu_ready", 32'(lu_ready), 32'(eready));
    check_eq("q_count", 32'(q_count), 32'(mq.size()));
    check_eq("q_busy", q_busy, ebusy);
    if (rf_wr) dut_rf[rf_a3] = rf_wd;

    @(posedge clk);
    if (pw) begin
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].dst == mwb.dst) begin
          e = mq[i]; e.live = 1'b0; mq[i] = e;
        end
      end
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
    end
    if (s.luv && eready && s.ludst != 5'd0) begin
      e.dst = s.ludst; e.data = s.ludata; e.live = 1'b1;
      mq.push_back(e);
    end
    if (s.flush) begin
      mwb.valid = 1'b0; mwb.done = 1'b0;
    end else if (s.stall) begin
      if (pw) mwb.done = 1'b1;
    end else begin
      mwb.valid = s.mv; mwb.regwrite = s.mrw; mwb.done = 1'b0;
      mwb.dst = s.mdst; mwb.wdsel = s.wdsel;
      mwb.alu = s.alu; mwb.mem = s.mem; mwb.pc4 = s.pc4;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Reset raised between edges must clear the write port and queue immediately.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rf_wr", 32'(rf_wr), 32'd0);
    check_eq("rst_q_count", 32'(q_count), 32'd0);
    check_eq("rst_q_busy", q_busy, 32'd0);
    check_eq("rst_lu_ready", 32'(lu_ready), 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    stim_t s;
    s = idle();
    rst = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; m_valid = 1'b0; m_regwrite = 1'b0;
    m_dst = 5'd0; m_wdsel = 2'b00; m_alu = 32'd0; m_mem = 32'd0; m_pc4 = 32'd0;
    lu_valid = 1'b0; lu_dst = 5'd0; lu_data = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ALU write, then bubble
    step(op(5'd5, 2'b00, 32'h0000_1234));
    step(idle());
    step(idle());

    // Memory and link sources, then dst=0 suppressed
    step(op(5'd8, 2'b01, 32'hDEAD_BEEF));
    step(op(5'd31, 2'b10, 32'h0040_0008));
    step(op(5'd0, 2'b00, 32'h5555_5555));
    step(idle());
    step(idle());

    // Queued result waits behind three pipeline writes
    step(with_lu(op(5'd1, 2'b00, 32'h1), 5'd3, 32'hAA));
    step(op(5'd2, 2'b00, 32'h2));
    step(op(5'd4, 2'b00, 32'h4));
    step(idle());
    step(idle());
    step(idle());
    check_eq("r3_final", dut_rf[3], 32'h0000_00AA);

    // Fill, refuse a third offer, drain across pointer wrap
    step(with_lu(op(5'd10, 2'b00, 32'h10), 5'd11, 32'hB1));
    step(with_lu(op(5'd12, 2'b00, 32'h12), 5'd13, 32'hB2));
    step(with_lu(op(5'd14, 2'b00, 32'h14), 5'd15, 32'hB3));
    step(idle());
    step(idle());
    step(with_lu(op(5'd16, 2'b00, 32'h16), 5'd17, 32'hB4));
    step(idle());
    step(idle());
    step(idle());

    // WAW squash of an older queued result
    step(with_lu(op(5'd20, 2'b00, 32'h20), 5'd7, 32'h11));
    step(op(5'd7, 2'b00, 32'h22));
    step(idle());
    step(idle());
    step(idle());
    check_eq("r7_final", dut_rf[7], 32'h0000_0022);

    // Stalled instruction writes once, queue drains behind it
    step(with_lu(op(5'd21, 2'b00, 32'h21), 5'd16, 32'hC1));
    step(with_lu(op(5'd22, 2'b00, 32'h22), 5'd17, 32'hC2));
    step(op(5'd9, 2'b00, 32'h99));
    step(stalled());
    step(stalled());
    step(stalled());
    step(stalled());
    step(idle());
    check_eq("r9_final", dut_rf[9], 32'h0000_0099);

    // Reset with a full queue
    step(with_lu(op(5'd23, 2'b00, 32'h23), 5'd18, 32'hD1));
    step(with_lu(op(5'd24, 2'b00, 32'h24), 5'd19, 32'hD2));
    async_reset();
    step(idle());
    step(idle());

    // Random traffic with a small destination range to provoke squashes
    for (int i = 0; i < 400; i++) begin
      s = rnd();
      step(s);
    end
    step(idle());
    step(idle());
    step(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
